// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select from execute redirects,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        MisalignF
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4d_q, pc4d_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;

    // Redirects bypass StallF; a target with bit 1 set is forced down to a word boundary.
    always_comb begin
        pc_plus4   = pc_q + 32'd4;
        redirect   = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
        target     = (PCSrcE == 2'b10) ? {ALUResultE[31:1], 1'b0} : PCTargetE;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect) begin
            if (target[1]) begin
                pc_d       = {target[31:2], 2'b00};
                misalign_d = 1'b1;
            end else begin
                pc_d = target;
            end
        end else if (!StallF) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc4d_d  = pc4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'd0;
            pc4d_d  = 32'd0;
            valid_d = 1'b0;
        end else if (!StallD) begin
            instr_d = InstrF;
            pcd_d   = pc_q;
            pc4d_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            instr_q    <= NOP_INSTR;
            pcd_q      <= 32'd0;
            pc4d_q     <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pc4d_q     <= pc4d_d;
            valid_q    <= valid_d;
        end
    end

    assign PCF       = pc_q;
    assign MisalignF = misalign_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pc4d_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan checks plus randomized traffic against a
// behavioural model of the fetch stage, compared every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE, InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, MisalignF;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid, m_mis;
    bit          fixed_imem = 1'b1;
    bit          check_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .InstrF(InstrF), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignF(MisalignF)
    );

    function automatic logic [31:0] imem(input logic [31:0] a, input bit fixed);
        if (fixed) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // instruction memory addressed by the model's PC
    assign InstrF = imem(m_pc, fixed_imem);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [31:0] old_pc, tgt;
        old_pc = m_pc;
        if (rst) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0;
            m_valid = 0; m_mis = 0;
            return;
        end
        if (PCSrcE == 2'd1 || PCSrcE == 2'd2) begin
            tgt = (PCSrcE == 2'd1) ? PCTargetE : (ALUResultE & 32'hFFFF_FFFE);
            if ((tgt % 4) >= 2) begin
                m_pc  = tgt - (tgt % 4);
                m_mis = 1;
            end else begin
                m_pc = tgt;
            end
        end else if (!StallF) begin
            m_pc = old_pc + 32'd4;
        end
        if (FlushD) begin
            m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 0;
        end else if (!StallD) begin
            m_instr = imem(old_pc, fixed_imem);
            m_pcd   = old_pc;
            m_pc4d  = old_pc + 32'd4;
            m_valid = 1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1 model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 2'b00;
        PCTargetE = 0; ALUResultE = 0;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("PCF", PCF, m_pc);
            check("InstrD", InstrD, m_instr);
            check("PCD", PCD, m_pcd);
            check("PCPlus4D", PCPlus4D, m_pc4d);
            check("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
            check("MisalignF", {31'd0, MisalignF}, {31'd0, m_mis});
        end
    end

    initial begin
        m_pc = 0; m_instr = 0; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_mis = 0;
        idle_inputs();
        rst = 1;
        cycle();
        check_en = 1;
        cycle();
        rst = 0;

        // 1: reset state, then free run
        check("t1_reset_valid", {31'd0, ValidD}, 32'd0);
        check("t1_reset_pc", PCF, 32'h0);
        check("t1_reset_instr", InstrD, NOP_INSTR);
        cycle();
        check("t1_pc4", PCF, 32'h4);
        check("t1_instr", InstrD, 32'h0050_0093);
        check("t1_valid", {31'd0, ValidD}, 32'd1);
        cycle();
        check("t1_pc8", PCF, 32'h8);
        check("t1_pcd4", PCD, 32'h4);

        // 2: full freeze for two cycles
        StallF = 1; StallD = 1;
        cycle(); cycle();
        check("t2_pc_hold", PCF, 32'h8);
        check("t2_pcd_hold", PCD, 32'h4);
        StallF = 0; StallD = 0;
        cycle();
        check("t2_pc12", PCF, 32'hC);
        check("t2_pcd8", PCD, 32'h8);

        // 3: branch with flush
        cycle();
        check("t3_pc10", PCF, 32'h10);
        PCSrcE = 2'b01; PCTargetE = 32'h40; FlushD = 1;
        cycle();
        idle_inputs();
        check("t3_pc40", PCF, 32'h40);
        check("t3_bubble_valid", {31'd0, ValidD}, 32'd0);
        check("t3_bubble_instr", InstrD, 32'h0000_0013);
        cycle();
        check("t3_pcd40", PCD, 32'h40);

        // 4: jalr wins over stall; misaligned target
        PCSrcE = 2'b10; ALUResultE = 32'h0000_0101; StallF = 1;
        cycle();
        check("t4_pc100", PCF, 32'h100);
        check("t4_mis0", {31'd0, MisalignF}, 32'd0);
        ALUResultE = 32'h0000_0106;
        cycle();
        idle_inputs();
        check("t4_pc104", PCF, 32'h104);
        check("t4_mis1", {31'd0, MisalignF}, 32'd1);

        // 5: PC wrap
        PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
        cycle();
        idle_inputs();
        check("t5_pcmax", PCF, 32'hFFFF_FFFC);
        cycle();
        check("t5_wrap_pc", PCF, 32'h0);
        check("t5_wrap_pc4d", PCPlus4D, 32'h0);
        check("t5_wrap_pcd", PCD, 32'hFFFF_FFFC);
        check("t5_mis_sticky", {31'd0, MisalignF}, 32'd1);

        // 6: reset during a stall
        PCSrcE = 2'b01; PCTargetE = 32'h20;
        cycle();
        idle_inputs();
        check("t6_pc20", PCF, 32'h20);
        StallF = 1; StallD = 1; rst = 1;
        cycle();
        idle_inputs();
        check("t6_rst_pc", PCF, RESET_PC);
        check("t6_rst_valid", {31'd0, ValidD}, 32'd0);
        check("t6_rst_mis", {31'd0, MisalignF}, 32'd0);

        // randomized traffic
        fixed_imem = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst    = ($urandom_range(0, 63) == 0);
            StallF = ($urandom_range(0, 3) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            FlushD = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 15);
            PCSrcE = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
            PCTargetE  = $urandom() & 32'hFFFF_FFFE;
            ALUResultE = $urandom();
            cycle();
        end
        idle_inputs();
        cycle();
        check_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core.
- Sits directly upstream of the decode/control path. It holds the PC, selects the next PC from the execute-stage redirect, drives the instruction-memory address, and registers the fetched word, PC and PC+4 for decode.
- Stall and flush inputs come from the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into decode on reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- StallF  in  1  hold PC (hazard unit).
- StallD  in  1  hold IF/ID register.
- FlushD  in  1  replace IF/ID contents with bubble.
- PCSrcE  in  2  next-PC select: 00 = PC+4, 01 = PCTargetE (branch/jal), 10 = ALUResultE (jalr), 11 = reserved.
- PCTargetE  in  32  PC+imm target from execute.
- ALUResultE  in  32  jalr target from execute.
- InstrF  in  32  instruction word from imem, combinational read of PCF.
- PCF  out  32  current fetch address to imem.
- InstrD  out  32  registered instruction to decode.
- PCD  out  32  registered PC of InstrD.
- PCPlus4D  out  32  registered PC+4 of InstrD.
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble).
- MisalignF  out  1  sticky: a redirect target was not 4-byte aligned.

Behaviour:
Reset:
- On rst=1 at a clock edge: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignF=0.
- Reset overrides all other inputs.
- Reset mid-stall or mid-redirect discards that operation entirely.

Next-PC selection (combinational):
- PCPlus4F = PCF+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- 00 gives PCPlus4F. 01 gives PCTargetE. 10 gives {ALUResultE[31:1],1'b0}, i.e. jalr bit0 cleared. 11 gives PCPlus4F.

PC register:
- A redirect (PCSrcE=01 or 10) always loads PCNext, even when StallF=1. Redirect has priority over stall.
- Otherwise: StallF=1 holds PCF; StallF=0 loads PCNext.
- Alignment: if a loaded redirect target has bit[1]=1, PCF loads {target[31:2],2'b00} and MisalignF sets.
- MisalignF stays set until rst.
- PC+4 is always aligned.

IF/ID register, priority rst > FlushD > StallD > load:
- FlushD=1: InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
- StallD=1 and FlushD=0: all D outputs hold.
- Otherwise: InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.

Timing:
- Latency: an instruction at PCF in cycle N appears on InstrD in cycle N+1.
- A redirect in cycle N makes PCF equal the target in N+1. The target's instruction reaches InstrD in N+2.
- The hazard unit is expected to assert FlushD together with a redirect. The block does not auto-flush.
- Simultaneous StallF=1, StallD=1 with no redirect: entire stage frozen, outputs unchanged.
- StallF=0 with StallD=1 is legal: the fetched word is dropped. The block does not check it.

Test Plan:
1. Reset then free-run, no stalls, InstrF=32'h00500093 -> ValidD=0 in the first cycle. Then PCF steps 0,4,8,12. PCD lags PCF by one cycle. InstrD=00500093, ValidD=1.
2. At PCF=8: StallF=StallD=1 for 2 cycles -> PCF stays 8 and InstrD/PCD=4 are held. Then PCF=12, PCD=8.
3. Branch: PCSrcE=01, PCTargetE=32'h40, FlushD=1 at PCF=0x10 -> next cycle PCF=0x40, ValidD=0, InstrD=00000013. The cycle after, PCD=0x40.
4. jalr: PCSrcE=10, ALUResultE=32'h0000_0101, StallF=1 -> redirect wins: PCF=0x100, MisalignF=0. Then ALUResultE=32'h0000_0106 -> PCF=0x104, MisalignF=1, and it stays 1 until rst.
5. PCF=32'hFFFF_FFFC, PCSrcE=00 -> PCF=0, PCPlus4D=0.
6. rst asserted during a stall with PCF=0x20 -> next cycle PCF=RESET_PC, ValidD=0, MisalignF=0.
